// File: rtl/div32_seq_if.sv
// Operand/result bundle between the divider and its requester (control unit / LO-HI path).
// The master drives start and operands; the slave (divider) returns status and results.
interface div32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Signed sequential divider: radix-2 restoring on magnitudes, then sign fix-up.
// Latency fixed at WIDTH+2 edges from accepted start to done; start ignored while busy.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div32_seq_if.slave div_if
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;

  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;
  logic [WIDTH+1:0] shift_d;
  logic [WIDTH+1:0] trial_d;
  logic             trial_neg_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;

  // Magnitudes; the most negative value maps onto itself and is read as unsigned.
  assign abs_a_d = div_if.dividend[WIDTH-1] ? -div_if.dividend : div_if.dividend;
  assign abs_b_d = div_if.divisor[WIDTH-1]  ? -div_if.divisor  : div_if.divisor;

  // One restoring step: the quotient bits accumulate in dvd_q as the dividend shifts out.
  assign shift_d     = {rem_q, dvd_q[WIDTH-1]};
  assign trial_d     = shift_d - {2'b00, dsr_q};
  assign trial_neg_d = trial_d[WIDTH+1];
  assign rem_d       = trial_neg_d ? shift_d[WIDTH:0] : trial_d[WIDTH:0];
  assign dvd_d       = {dvd_q[WIDTH-2:0], ~trial_neg_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (div_if.start) begin
            sign_a_q <= div_if.dividend[WIDTH-1];
            sign_b_q <= div_if.divisor[WIDTH-1];
            dvd_q    <= abs_a_d;
            dsr_q    <= abs_b_d;
            rem_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end

        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end

        FIX: begin
          // With a zero divisor every trial succeeds, so rem_q already holds |dividend|
          // and the signed remainder reconstructs the dividend exactly.
          if (dsr_q == '0) begin
            quo_q <= '1;
            dbz_q <= 1'b1;
          end else begin
            quo_q <= (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
            dbz_q <= 1'b0;
          end
          rmd_q   <= sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quo_q;
  assign div_if.remainder   = rmd_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
Multi-cycle signed integer divider, the inverse-direction companion to the combinational 32x32 multiplier in the processor datapath. It accepts a dividend and divisor on a start strobe. It runs a fixed-latency radix-2 restoring division on operand magnitudes and returns a signed quotient and remainder. These feed the LO/HI register pair, with a one-cycle done pulse for the control unit.

Parameters:
WIDTH, 32, operand/quotient/remainder width; iteration counter is clog2(WIDTH)+1 bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  signed dividend, captured on accepted start
divisor  input  WIDTH  signed divisor, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid from this cycle until the next accepted start
quotient  output  WIDTH  signed quotient (LO)
remainder  output  WIDTH  signed remainder (HI)
div_by_zero  output  1  valid with done; high when the captured divisor was 0

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset: state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. The counter and internal operand registers are cleared.
- Reset mid-operation: the in-flight division is abandoned with no done pulse. Outputs are zeroed on the reset edge.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE -> RUN: on a clock edge with start=1. The block then:
  - captures the dividend sign, divisor sign, |dividend| and |divisor| (|-2^31| is held as unsigned 0x80000000);
  - clears the partial remainder and sets count=0;
  - sets busy=1 and done=0.
- RUN, every edge:
  - shift {rem, dvd} left by 1;
  - trial-subtract |divisor| from the WIDTH+1-bit rem;
  - if the result is non-negative, keep it and set the quotient LSB to 1, otherwise restore rem and set the LSB to 0;
  - count++. After WIDTH iterations (count==WIDTH-1 at the edge), go to FIX.
- FIX, one edge:
  - quotient = sign_a XOR sign_b ? -q : q;
  - remainder = sign_a ? -r : r;
  - go to DONE, with busy=0 and done=1 for exactly one cycle.
- DONE: outputs hold and done deasserts on the next edge. DONE accepts start exactly like IDLE. With no start, DONE returns to IDLE and outputs keep holding.
- Latency is fixed and data-independent. Counting the start-sampling edge as edge 1, done is high during the cycle after edge WIDTH+2 (edge 34 for WIDTH=32). Back-to-back issue is allowed: a start during the done cycle begins the next division on that edge.
- start while busy=1 is ignored, with no queueing. Changes on dividend/divisor after capture have no effect.
- Arithmetic is truncating (C semantics), matching Verilog $signed(a)/$signed(b) and %:
  - quotient rounds toward zero;
  - the remainder has the dividend's sign;
  - quotient*divisor + remainder == dividend mod 2^WIDTH.
- Overflow: -2^31 / -1 gives quotient=0x80000000, remainder=0, div_by_zero=0.
- Divide by zero:
  - the full latency still elapses;
  - quotient=all ones (0xFFFFFFFF), remainder=dividend, div_by_zero=1.
  - These values are forced in FIX, independent of signs.
- div_by_zero updates only in FIX and holds with the results.

Test Plan:
1. rst, then dividend=100, divisor=7, start for 1 cycle -> busy=1 for 33 cycles. done pulses once at edge 34; quotient=14, remainder=2, div_by_zero=0.
2. Sign cases:
   - -100/7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2);
   - 100/-7 -> q=-14, r=2;
   - -100/-7 -> q=14, r=-2.
3. Edge operands:
   - 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0;
   - 0x80000000/1 -> q=0x80000000, r=0;
   - 0x7FFFFFFF/0x80000000 -> q=0, r=0x7FFFFFFF;
   - 0/5 -> q=0, r=0.
4. 1234/0 -> done at edge 34, q=0xFFFFFFFF, r=1234, div_by_zero=1. A following 9/3 -> q=3, r=0, div_by_zero=0.
5. Handshake:
   - start=1 held through a run with inputs changed to 50/5 at cycle 10 -> first result still 100/7;
   - a second division (50/5) starts on the done cycle, and its done arrives exactly 34 edges after the first done.
6. Reset mid-operation: rst=1 at cycle 15 of a run -> next cycle busy=0, done=0, outputs=0, and no done pulse follows. Then 10k random {dividend, divisor} pairs compared against $signed / and % (divisor 0 checked against the rule above) -> zero mismatches.
